// File: rtl/uc_multiciclo_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// The control unit connects through the slave modport, the datapath through the master.
interface uc_multiciclo_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [6:0]            op;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic                  zero;
  logic                  mem_ready;
  logic                  pcWrite;
  logic                  adrSrc;
  logic                  memWrite;
  logic                  irWrite;
  logic [1:0]            resultSrc;
  logic [1:0]            aluSrcA;
  logic [1:0]            aluSrcB;
  logic [1:0]            immSrc;
  logic                  regWrite;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic                  illegal_op;
  logic [3:0]            state;

  modport slave (
    input  op, f3, f7, zero, mem_ready,
    output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
           immSrc, regWrite, aluControl, illegal_op, state
  );

  modport master (
    output op, f3, f7, zero, mem_ready,
    input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
           immSrc, regWrite, aluControl, illegal_op, state
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM plus ALU, immediate and branch decoders.
// Define UC_BRANCH_EXT_EN to add bne (f3=001) and reject other branch funct3 codes.
module uc_multiciclo #(
  parameter int ALU_CTRL_W    = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  uc_multiciclo_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;

  state_t                state_q;
  state_t                state_d;
  logic                  mem_rdy_s;
  logic                  branch_f3_ok_s;
  logic                  op_legal_s;
  logic                  taken_s;
  logic                  pc_update_s;
  logic                  branch_s;
  logic                  adr_src_s;
  logic                  mem_write_s;
  logic                  ir_write_s;
  logic                  reg_write_s;
  logic                  illegal_s;
  logic [1:0]            result_src_s;
  logic [1:0]            alu_src_a_s;
  logic [1:0]            alu_src_b_s;
  logic [1:0]            alu_op_s;
  logic [1:0]            imm_src_s;
  logic [2:0]            alu_ctrl3_s;
  logic [ALU_CTRL_W-1:0] alu_control_s;
  logic                  f7_unused_s;

  assign mem_rdy_s   = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign f7_unused_s = ^{bus.f7[6], bus.f7[4:0]};

`ifdef UC_BRANCH_EXT_EN
  assign branch_f3_ok_s = (bus.f3 == 3'b000) || (bus.f3 == 3'b001);
`else
  assign branch_f3_ok_s = 1'b1;
`endif

  // Opcode legality as seen by DECODE.
  always_comb begin
    case (bus.op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL: op_legal_s = 1'b1;
      OP_BRANCH:                                     op_legal_s = branch_f3_ok_s;
      default:                                       op_legal_s = 1'b0;
    endcase
  end

  // State register; reset drops straight back to FETCH without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_rdy_s) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if (!op_legal_s) begin
          state_d = S_FETCH;
        end else begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECUTER;
            OP_ITYPE:          state_d = S_EXECUTEI;
            OP_JAL:            state_d = S_JAL;
            OP_BRANCH:         state_d = S_BEQ;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (bus.op == OP_LOAD)       state_d = S_MEMREAD;
        else if (bus.op == OP_STORE) state_d = S_MEMWRITE;
        else                         state_d = S_FETCH;
      end
      S_MEMREAD: begin
        if (mem_rdy_s) state_d = S_MEMWB;
        else           state_d = S_MEMREAD;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_rdy_s) state_d = S_FETCH;
        else           state_d = S_MEMWRITE;
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state control outputs; anything not set by a state stays 0.
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_rdy_s;
        pc_update_s  = mem_rdy_s;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        illegal_s   = ~op_legal_s;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Branch condition, evaluated live on the ALU zero flag.
  always_comb begin
`ifdef UC_BRANCH_EXT_EN
    case (bus.f3)
      3'b000:  taken_s = bus.zero;
      3'b001:  taken_s = ~bus.zero;
      default: taken_s = 1'b0;
    endcase
`else
    taken_s = bus.zero;
`endif
  end

  // Immediate format select from the opcode.
  always_comb begin
    case (bus.op)
      OP_LOAD, OP_ITYPE: imm_src_s = 2'b00;
      OP_STORE:          imm_src_s = 2'b01;
      OP_BRANCH:         imm_src_s = 2'b10;
      OP_JAL:            imm_src_s = 2'b11;
      default:           imm_src_s = 2'b00;
    endcase
  end

  // ALU decoder; op[5] separates R-type sub from I-type addi.
  always_comb begin
    case (alu_op_s)
      2'b00: alu_ctrl3_s = 3'b000;
      2'b01: alu_ctrl3_s = 3'b001;
      2'b10: begin
        case (bus.f3)
          3'b000: begin
            if (bus.op[5] && bus.f7[5]) alu_ctrl3_s = 3'b001;
            else                        alu_ctrl3_s = 3'b000;
          end
          3'b010:  alu_ctrl3_s = 3'b101;
          3'b110:  alu_ctrl3_s = 3'b011;
          3'b111:  alu_ctrl3_s = 3'b010;
          default: alu_ctrl3_s = 3'b000;
        endcase
      end
      default: alu_ctrl3_s = 3'b000;
    endcase
  end

  // Widen the 3-bit ALU code; upper bits are always zero.
  always_comb begin
    alu_control_s      = {ALU_CTRL_W{1'b0}};
    alu_control_s[2:0] = alu_ctrl3_s;
  end

  // Write enables are masked by rst_n so nothing fires while reset is held.
  assign bus.pcWrite    = rst_n & (pc_update_s | (branch_s & taken_s));
  assign bus.memWrite   = rst_n & mem_write_s;
  assign bus.irWrite    = rst_n & ir_write_s;
  assign bus.regWrite   = rst_n & reg_write_s;
  assign bus.illegal_op = rst_n & illegal_s;
  assign bus.adrSrc     = adr_src_s;
  assign bus.resultSrc  = result_src_s;
  assign bus.aluSrcA    = alu_src_a_s;
  assign bus.aluSrcB    = alu_src_b_s;
  assign bus.immSrc     = imm_src_s;
  assign bus.aluControl = alu_control_s;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: walks each instruction class through the FSM.
module tb_uc_multiciclo;
  localparam int AW = 4;
`ifdef UC_BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  uc_multiciclo_if #(.ALU_CTRL_W(AW)) bus ();

  uc_multiciclo #(.ALU_CTRL_W(AW), .MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.op = 7'd3;
    bus.f3 = 3'b000; bus.f7 = 7'd0; bus.zero = 1'b0;
    #3;
    n_total++;
    if (bus.state !== 4'd0 || bus.irWrite !== 1'b0 || bus.pcWrite !== 1'b0 ||
        bus.memWrite !== 1'b0 || bus.regWrite !== 1'b0 || bus.illegal_op !== 1'b0)
      $display("FAIL reset_hold: state=%0d ir=%b pc=%b mw=%b rw=%b ill=%b required 0 0 0 0 0 0",
               bus.state, bus.irWrite, bus.pcWrite, bus.memWrite, bus.regWrite, bus.illegal_op);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0 || bus.irWrite !== 1'b0 || bus.pcWrite !== 1'b0)
      $display("FAIL reset_clocked: state=%0d ir=%b pc=%b required 0 0 0",
               bus.state, bus.irWrite, bus.pcWrite);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.state !== 4'd0 || bus.irWrite !== 1'b1 || bus.pcWrite !== 1'b1 ||
        bus.adrSrc !== 1'b0 || bus.aluSrcA !== 2'b00 || bus.aluSrcB !== 2'b10 ||
        bus.resultSrc !== 2'b10 || bus.aluControl !== 4'b0000)
      $display("FAIL fetch_after_reset: state=%0d ir=%b pc=%b adr=%b a=%b b=%b res=%b alu=%b required 0 1 1 0 00 10 10 0000",
               bus.state, bus.irWrite, bus.pcWrite, bus.adrSrc, bus.aluSrcA, bus.aluSrcB,
               bus.resultSrc, bus.aluControl);
    else n_pass++;
  endtask

  task automatic test_fetch_stall();
    bus.mem_ready = 1'b0;
    #1;
    n_total++;
    if (bus.irWrite !== 1'b0 || bus.pcWrite !== 1'b0)
      $display("FAIL fetch_stall_en: ir=%b pc=%b required 0 0", bus.irWrite, bus.pcWrite);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0)
      $display("FAIL fetch_stall_state: state=%0d required 0", bus.state);
    else n_pass++;
    bus.mem_ready = 1'b1;
    #1;
    n_total++;
    if (bus.irWrite !== 1'b1 || bus.pcWrite !== 1'b1)
      $display("FAIL fetch_release: ir=%b pc=%b required 1 1", bus.irWrite, bus.pcWrite);
    else n_pass++;
  endtask

  task automatic test_lw();
    bus.op = 7'd3;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd1 || bus.aluSrcA !== 2'b01 || bus.aluSrcB !== 2'b01 ||
        bus.irWrite !== 1'b0 || bus.pcWrite !== 1'b0)
      $display("FAIL lw_decode: state=%0d a=%b b=%b ir=%b pc=%b required 1 01 01 0 0",
               bus.state, bus.aluSrcA, bus.aluSrcB, bus.irWrite, bus.pcWrite);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd2 || bus.aluSrcA !== 2'b10 || bus.aluSrcB !== 2'b01 || bus.immSrc !== 2'b00)
      $display("FAIL lw_memadr: state=%0d a=%b b=%b imm=%b required 2 10 01 00",
               bus.state, bus.aluSrcA, bus.aluSrcB, bus.immSrc);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd3 || bus.adrSrc !== 1'b1 || bus.resultSrc !== 2'b00 || bus.regWrite !== 1'b0)
      $display("FAIL lw_memread: state=%0d adr=%b res=%b rw=%b required 3 1 00 0",
               bus.state, bus.adrSrc, bus.resultSrc, bus.regWrite);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd4 || bus.resultSrc !== 2'b01 || bus.regWrite !== 1'b1 || bus.memWrite !== 1'b0)
      $display("FAIL lw_memwb: state=%0d res=%b rw=%b mw=%b required 4 01 1 0",
               bus.state, bus.resultSrc, bus.regWrite, bus.memWrite);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0 || bus.regWrite !== 1'b0)
      $display("FAIL lw_done: state=%0d rw=%b required 0 0", bus.state, bus.regWrite);
    else n_pass++;
  endtask

  task automatic test_alu_op(input logic [6:0] opv, input logic [2:0] f3v, input logic [6:0] f7v,
                             input logic [3:0] exp_state, input logic [1:0] exp_b,
                             input logic [3:0] exp_alu);
    bus.op = opv; bus.f3 = f3v; bus.f7 = f7v;
    next_cycle();
    next_cycle();
    n_total++;
    if (bus.state !== exp_state || bus.aluSrcA !== 2'b10 || bus.aluSrcB !== exp_b ||
        bus.aluControl !== exp_alu || bus.regWrite !== 1'b0)
      $display("FAIL alu_execute op=%0d f3=%b: state=%0d a=%b b=%b alu=%b rw=%b required %0d 10 %b %b 0",
               opv, f3v, bus.state, bus.aluSrcA, bus.aluSrcB, bus.aluControl, bus.regWrite,
               exp_state, exp_b, exp_alu);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd7 || bus.regWrite !== 1'b1 || bus.resultSrc !== 2'b00)
      $display("FAIL alu_wb op=%0d: state=%0d rw=%b res=%b required 7 1 00",
               opv, bus.state, bus.regWrite, bus.resultSrc);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0)
      $display("FAIL alu_done op=%0d: state=%0d required 0", opv, bus.state);
    else n_pass++;
  endtask

  task automatic test_jal();
    bus.op = 7'd111; bus.f3 = 3'b000; bus.f7 = 7'd0;
    next_cycle();
    next_cycle();
    n_total++;
    if (bus.state !== 4'd9 || bus.pcWrite !== 1'b1 || bus.aluSrcA !== 2'b01 ||
        bus.aluSrcB !== 2'b10 || bus.immSrc !== 2'b11 || bus.resultSrc !== 2'b00)
      $display("FAIL jal_state: state=%0d pc=%b a=%b b=%b imm=%b res=%b required 9 1 01 10 11 00",
               bus.state, bus.pcWrite, bus.aluSrcA, bus.aluSrcB, bus.immSrc, bus.resultSrc);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd7 || bus.regWrite !== 1'b1 || bus.pcWrite !== 1'b0)
      $display("FAIL jal_wb: state=%0d rw=%b pc=%b required 7 1 0", bus.state, bus.regWrite, bus.pcWrite);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_sw_stall();
    bus.op = 7'd35;
    next_cycle();
    next_cycle();
    n_total++;
    if (bus.state !== 4'd2 || bus.immSrc !== 2'b01 || bus.memWrite !== 1'b0)
      $display("FAIL sw_memadr: state=%0d imm=%b mw=%b required 2 01 0", bus.state, bus.immSrc, bus.memWrite);
    else n_pass++;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      n_total++;
      if (bus.state !== 4'd5 || bus.memWrite !== 1'b1 || bus.adrSrc !== 1'b1 || bus.resultSrc !== 2'b00)
        $display("FAIL sw_stall_%0d: state=%0d mw=%b adr=%b res=%b required 5 1 1 00",
                 i, bus.state, bus.memWrite, bus.adrSrc, bus.resultSrc);
      else n_pass++;
    end
    next_cycle();
    bus.mem_ready = 1'b1;
    #1;
    n_total++;
    if (bus.state !== 4'd5 || bus.memWrite !== 1'b1)
      $display("FAIL sw_last: state=%0d mw=%b required 5 1", bus.state, bus.memWrite);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0 || bus.memWrite !== 1'b0)
      $display("FAIL sw_done: state=%0d mw=%b required 0 0", bus.state, bus.memWrite);
    else n_pass++;
  endtask

  task automatic test_beq();
    bus.op = 7'd99; bus.f3 = 3'b000; bus.zero = 1'b1;
    next_cycle();
    next_cycle();
    n_total++;
    if (bus.state !== 4'd10 || bus.pcWrite !== 1'b1 || bus.aluControl !== 4'b0001 ||
        bus.immSrc !== 2'b10 || bus.aluSrcA !== 2'b10 || bus.aluSrcB !== 2'b00)
      $display("FAIL beq_taken: state=%0d pc=%b alu=%b imm=%b a=%b b=%b required 10 1 0001 10 10 00",
               bus.state, bus.pcWrite, bus.aluControl, bus.immSrc, bus.aluSrcA, bus.aluSrcB);
    else n_pass++;
    bus.zero = 1'b0;
    #1;
    n_total++;
    if (bus.pcWrite !== 1'b0)
      $display("FAIL beq_not_taken: pc=%b required 0", bus.pcWrite);
    else n_pass++;
    bus.f3 = 3'b001;
    #1;
    n_total++;
    if (bus.pcWrite !== EXT)
      $display("FAIL bne_zero0: pc=%b required %b", bus.pcWrite, EXT);
    else n_pass++;
    bus.zero = 1'b1;
    #1;
    n_total++;
    if (bus.pcWrite !== ~EXT)
      $display("FAIL bne_zero1: pc=%b required %b", bus.pcWrite, ~EXT);
    else n_pass++;
    next_cycle();
    bus.f3 = 3'b010; bus.zero = 1'b0;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd1 || bus.illegal_op !== EXT)
      $display("FAIL branch_f3_010_decode: state=%0d ill=%b required 1 %b", bus.state, bus.illegal_op, EXT);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== (EXT ? 4'd0 : 4'd10) || bus.illegal_op !== 1'b0)
      $display("FAIL branch_f3_010_next: state=%0d ill=%b required %0d 0",
               bus.state, bus.illegal_op, (EXT ? 4'd0 : 4'd10));
    else n_pass++;
    if (!EXT) next_cycle();
    bus.f3 = 3'b000;
  endtask

  task automatic test_illegal();
    bus.op = 7'h7F;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd1 || bus.illegal_op !== 1'b1)
      $display("FAIL illegal_decode: state=%0d ill=%b required 1 1", bus.state, bus.illegal_op);
    else n_pass++;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0 || bus.irWrite !== 1'b1)
      $display("FAIL illegal_next: state=%0d ill=%b ir=%b required 0 0 1",
               bus.state, bus.illegal_op, bus.irWrite);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.op = 7'd35;
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    next_cycle();
    n_total++;
    if (bus.state !== 4'd5 || bus.memWrite !== 1'b1)
      $display("FAIL rmid_memwrite: state=%0d mw=%b required 5 1", bus.state, bus.memWrite);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.state !== 4'd0 || bus.memWrite !== 1'b0 || bus.regWrite !== 1'b0 ||
        bus.pcWrite !== 1'b0 || bus.irWrite !== 1'b0)
      $display("FAIL rmid_async: state=%0d mw=%b rw=%b pc=%b ir=%b required 0 0 0 0 0",
               bus.state, bus.memWrite, bus.regWrite, bus.pcWrite, bus.irWrite);
    else n_pass++;
    next_cycle();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_total++;
    if (bus.state !== 4'd0 || bus.irWrite !== 1'b1 || bus.memWrite !== 1'b0)
      $display("FAIL rmid_release: state=%0d ir=%b mw=%b required 0 1 0",
               bus.state, bus.irWrite, bus.memWrite);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_fetch_stall();
    test_lw();
    test_alu_op(7'd51, 3'b000, 7'b0110000, 4'd6, 2'b00, 4'b0001);
    test_alu_op(7'd51, 3'b111, 7'b0000000, 4'd6, 2'b00, 4'b0010);
    test_alu_op(7'd51, 3'b110, 7'b0000000, 4'd6, 2'b00, 4'b0011);
    test_alu_op(7'd19, 3'b000, 7'b0100000, 4'd8, 2'b01, 4'b0000);
    test_alu_op(7'd19, 3'b010, 7'b0000000, 4'd8, 2'b01, 4'b0101);
    test_jal();
    test_sw_stall();
    test_beq();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
